// File: rtl/prv32_muldiv_unit.sv
// prv32_muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. A request is
//   accepted with a valid/ready handshake. The operands are turned into
//   magnitudes, then processed one bit per cycle: shift-add for multiplies,
//   restoring division for divides. A fixup cycle then applies the recorded
//   result sign. The result is held until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   op         funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b       rs1 / rs2 operands (XLEN bits)
//   out_valid  result valid
//   out_ready  consumer takes the result
//   result     result (XLEN bits)
//   busy       request accepted and result not yet consumed
module prv32_muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned     CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_mb;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_lo;
  logic              r_neg_rem;

  logic              w_signed_a;
  logic              w_signed_b;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_ma;
  logic [XLEN-1:0]   w_mb;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic              w_early;
  logic [XLEN-1:0]   w_early_res;

  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_acc_step;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_res;

  // Operand decode on the latched request
  always_comb begin
    w_signed_a = (r_op == 3'b001) || (r_op == 3'b010) ||
                 (r_op == 3'b100) || (r_op == 3'b110);
    w_signed_b = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
    w_sa       = w_signed_a & r_a[XLEN-1];
    w_sb       = w_signed_b & r_b[XLEN-1];
    w_ma       = w_sa ? -r_a : r_a;
    w_mb       = w_sb ? -r_b : r_b;
    w_b_zero   = (r_b == '0);
    // w_signed_b together with op[2] selects DIV/REM
    w_ovf      = w_signed_b && r_op[2] && (r_a == MOST_NEG) && (r_b == '1);
    w_special  = r_op[2] && (w_b_zero || w_ovf);
    w_early    = (EARLY_OUT != 0) && w_special;
    if (w_b_zero) begin
      w_early_res = r_op[1] ? r_a : '1;
    end else begin
      w_early_res = r_op[1] ? '0 : r_a;
    end
  end

  // One iteration: r_acc = {high word, low word}. Both start as {0, |a|}.
  // Multiply: low word is the multiplier shifting out, high word the sum.
  // Divide: low word is the dividend shifting out / quotient shifting in,
  // high word the partial remainder.
  always_comb begin
    w_hi      = r_acc[2*XLEN-1:XLEN];
    w_lo      = r_acc[XLEN-1:0];
    w_mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_mb} : '0);
    w_rem_sh  = {w_hi, w_lo[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, r_mb};
    if (r_op[2]) begin
      // Borrow out (bit XLEN) means the shifted remainder was below the divisor
      if (!w_diff[XLEN]) begin
        w_acc_step = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
      end else begin
        w_acc_step = {w_rem_sh[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_acc_step = {w_mul_sum, w_lo[XLEN-1:1]};
    end
  end

  // Sign fixup and result select
  always_comb begin
    w_prod = r_neg_lo ? -r_acc : r_acc;
    w_quo  = r_neg_lo ? -w_lo : w_lo;
    w_rem  = r_neg_rem ? -w_hi : w_hi;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_PREP;
      S_PREP:  w_state_next = w_early ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == LAST) w_state_next = S_FIXUP;
      S_FIXUP: w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_DONE);
    result    = r_result;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_mb      <= '0;
      r_result  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end
        end
        S_PREP: begin
          r_cnt     <= '0;
          r_mb      <= w_mb;
          r_acc     <= {{XLEN{1'b0}}, w_ma};
          // A zero divisor yields an all-ones quotient magnitude that must
          // stay unsigned so the full path matches the early-out value
          r_neg_lo  <= (w_sa ^ w_sb) & ~(r_op[2] & w_b_zero);
          r_neg_rem <= w_sa;
          if (w_early) begin
            r_result <= w_early_res;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= w_acc_step;
        end
        S_FIXUP: begin
          r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prv32_muldiv_unit.sv
// Testbench for prv32_muldiv_unit: three instances (XLEN=32 with early out,
// XLEN=32 full latency, XLEN=8 with early out) checked against an
// arithmetic reference model of RV32M semantics.
module tb_prv32_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       iv;
  logic [2:0]       ordy;
  logic [2:0][2:0]  opv;
  logic [1:0][31:0] av;
  logic [1:0][31:0] bv;
  logic [7:0]       a8;
  logic [7:0]       b8;
  wire  [2:0]       ir;
  wire  [2:0]       ov;
  wire  [2:0]       bz;
  wire  [1:0][31:0] rv;
  wire  [7:0]       r8;

  int n_checks = 0;
  int n_pass   = 0;

  prv32_muldiv_unit #(.XLEN(32), .EARLY_OUT(1)) u_dut_eo (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
    .a(av[0]), .b(bv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(rv[0]), .busy(bz[0])
  );

  prv32_muldiv_unit #(.XLEN(32), .EARLY_OUT(0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
    .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(rv[1]), .busy(bz[1])
  );

  prv32_muldiv_unit #(.XLEN(8), .EARLY_OUT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op(opv[2]),
    .a(a8), .b(b8), .out_valid(ov[2]), .out_ready(ordy[2]),
    .result(r8), .busy(bz[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic get_ir(input int d);
    case (d)
      0: return ir[0];
      1: return ir[1];
      default: return ir[2];
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0: return ov[0];
      1: return ov[1];
      default: return ov[2];
    endcase
  endfunction

  function automatic logic get_bz(input int d);
    case (d)
      0: return bz[0];
      1: return bz[1];
      default: return bz[2];
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int d);
    case (d)
      0: return rv[0];
      1: return rv[1];
      default: return {24'h0, r8};
    endcase
  endfunction

  task automatic drive(input int d, input logic v, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    case (d)
      0: begin iv[0] = v; opv[0] = o; av[0] = x; bv[0] = y; end
      1: begin iv[1] = v; opv[1] = o; av[1] = x; bv[1] = y; end
      default: begin iv[2] = v; opv[2] = o; a8 = x[7:0]; b8 = y[7:0]; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic v);
    case (d)
      0: ordy[0] = v;
      1: ordy[1] = v;
      default: ordy[2] = v;
    endcase
  endtask

  // Reference model: plain wide arithmetic on sign-extended values
  function automatic longint to_s(input longint unsigned u, input int xl);
    longint one;
    one = 1;
    if (((u >> (xl - 1)) & 64'd1) != 0) return longint'(u) - (one << xl);
    return longint'(u);
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int xl);
    longint unsigned mask, ua, ub, r;
    longint sa, sb, minv, one;
    one  = 1;
    mask = (64'd1 << xl) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = to_s(ua, xl);
    sb   = to_s(ub, xl);
    minv = -(one << (xl - 1));
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = $unsigned((sa * sb) >>> xl);
      3'd2: r = $unsigned((sa * longint'(ub)) >>> xl);
      3'd3: r = (ua * ub) >> xl;
      3'd4: if (ub == 0) r = mask;
            else if (sa == minv && sb == -1) r = ua;
            else r = $unsigned(sa / sb);
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: if (ub == 0) r = ua;
            else if (sa == minv && sb == -1) r = 0;
            else r = $unsigned(sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int exp_lat(input int d, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    int xl;
    longint unsigned mask, ua, ub;
    longint sa, sb, minv, one;
    bit special;
    xl   = (d == 2) ? 8 : 32;
    one  = 1;
    mask = (64'd1 << xl) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = to_s(ua, xl);
    sb   = to_s(ub, xl);
    minv = -(one << (xl - 1));
    special = op[2] && ((ub == 0) ||
              ((op == 3'd4 || op == 3'd6) && sa == minv && sb == -1));
    if (d != 1 && special) return 1;
    return xl + 2;
  endfunction

  // One transaction; hold = cycles out_ready stays low after out_valid
  // (hold 0 keeps out_ready high from before acceptance)
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp, held;
    int lat, n, xl;
    bit ready_seen, idle_seen;
    xl  = (d == 2) ? 8 : 32;
    exp = ref_res(op, a, b, xl);
    lat = exp_lat(d, op, a, b);
    check($sformatf("d%0d op%0d idle_before", d, op), 32'(get_ir(d)), 32'd1);
    @(negedge clk);
    drive(d, 1'b1, op, a, b);
    set_ordy(d, hold == 0);
    @(posedge clk);
    #1;
    drive(d, 1'b0, 3'($urandom), $urandom, $urandom);
    n = 0;
    ready_seen = 0;
    idle_seen  = 0;
    while (!get_ov(d) && n < lat + 20) begin
      if (get_ir(d)) ready_seen = 1;
      if (!get_bz(d)) idle_seen = 1;
      @(posedge clk);
      #1;
      n++;
      drive(d, 1'b0, 3'($urandom), $urandom, $urandom);
    end
    check($sformatf("d%0d op%0d latency", d, op), 32'(n), 32'(lat));
    check($sformatf("d%0d op%0d result a=%h b=%h", d, op, a, b), get_res(d), exp);
    check($sformatf("d%0d op%0d ready_low_busy_high", d, op),
          32'({ready_seen, idle_seen}), 32'd0);
    held = get_res(d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("d%0d hold%0d stable", d, i), get_res(d), held);
      check($sformatf("d%0d hold%0d valid_notready", d, i),
            32'({get_ov(d), get_ir(d)}), 32'd2);
    end
    if (hold > 0) set_ordy(d, 1'b1);
    @(posedge clk);
    #1;
    check($sformatf("d%0d op%0d released", d, op),
          32'({get_ov(d), get_ir(d), get_bz(d)}), 32'b010);
    check($sformatf("d%0d op%0d result_kept", d, op), get_res(d), exp);
    set_ordy(d, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    int d;
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    opv   = '0;
    av    = '0;
    bv    = '0;
    a8    = '0;
    b8    = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d reset ctrl", k),
            32'({get_ir(k), get_ov(k), get_bz(k)}), 32'b100);
      check($sformatf("d%0d reset result", k), get_res(k), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases on both 32-bit instances
    for (int k = 0; k < 2; k++) begin
      run_op(k, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(k, 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(k, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(k, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
      run_op(k, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(k, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(k, 3'd5, 32'd100, 32'd7, 0);
      run_op(k, 3'd7, 32'd100, 32'd7, 5);
      run_op(k, 3'd5, 32'd5, 32'd0, 0);
      run_op(k, 3'd6, 32'd5, 32'd0, 0);
      run_op(k, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(k, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3);
      run_op(k, 3'd4, 32'hFFFF_FFF9, 32'd0, 0);
    end
    run_op(2, 3'd0, 32'h0F, 32'h0F, 0);
    run_op(2, 3'd4, 32'h80, 32'hFF, 1);
    run_op(2, 3'd6, 32'hF9, 32'h02, 0);

    // Randomised cases across all instances
    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 2);
      op = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = (d == 2) ? 32'h80 : 32'h8000_0000; rb = (d == 2) ? 32'hFF : 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 20);
        default: ;
      endcase
      if (d == 2) begin
        ra = ra & 32'hFF;
        rb = rb & 32'hFF;
      end
      run_op(d, op, ra, rb, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of CALC (counter at 10)
    check("rst idle_before", 32'(get_ir(0)), 32'd1);
    @(negedge clk);
    drive(0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd3);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst mid ctrl", 32'({get_ir(0), get_ov(0), get_bz(0)}), 32'b100);
    check("rst mid result", get_res(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst no_late_result", 32'(get_ov(0)), 32'd0);
    run_op(0, 3'd5, 32'd9, 32'd3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
